path_trace_writer: RTL and testbench
====================================

// Module: path_trace_writer
// PURPOSE
//  Back end of the shortest-path engine: after relaxation completes, walks the predecessor
//  memory from destination back to source and writes the path into the result RAM in
//  forward order (source first), terminated by 16'h0000.
//  The result RAM is the one the output dump reads. That reader prints 16'hFFFF verbatim,
//  stops at 16'h0000 and prints every other word as a decimal node ID.
//  Node IDs are 1-based; 0 is reserved as the terminator.
// PARAMETERS
//  ADDR_W     14    result-RAM and predecessor-RAM address width
//  DATA_W     16    word width of both memories
//  MAX_NODES  256   hop limit; a walk exceeding it is treated as a corrupt/cyclic predecessor chain
// PORTS
//  clock          in   1       single clock, rising edge
//  reset          in   1       synchronous, active-high
//  start          in   1       one-cycle pulse; accepted only while busy=0
//  n_exist_in     in   1       negative-cycle flag from relaxation engine; sampled with start
//  source         in   DATA_W  source node ID, sampled with start
//  destination    in   DATA_W  destination node ID, sampled with start
//  pred_re        out  1       predecessor RAM read enable
//  pred_addr      out  ADDR_W  predecessor RAM address (= node ID)
//  pred_data      in   DATA_W  predecessor word; valid the cycle after pred_re; FFFF or 0 = none
//  out_we         out  1       result RAM write strobe, one word per cycle
//  out_addr       out  ADDR_W  result RAM address
//  out_data       out  DATA_W  result word
//  busy           out  1       high from the cycle after start until done
//  done           out  1       goes high when the terminator is written; held until next start or reset
//  unreach        out  1       valid with done: no path, or negative cycle, or hop limit hit
//  path_len       out  ADDR_W  valid with done: node count written (0 when unreach)
// BEHAVIOUR
//  Reset: all outputs 0; FSM goes to IDLE; internal counters cleared.
//  Reset mid-walk: abort at the next edge; no further out_we; no partial terminator is written.
//  FSM states: IDLE, CNT_RD, CNT_WAIT, WR_TERM, WR_NODE, WR_RD, WR_WAIT, FAIL, DONE.
//  IDLE
//   - On start: latch source, destination and n_exist_in; set busy; clear done, unreach, path_len.
//   - If n_exist_in=1 -> FAIL.
//   - Else if destination==source -> WR_TERM with len=1.
//   - Else cur=destination, len=1 -> CNT_RD.
//  Pass 1, count (CNT_RD -> CNT_WAIT)
//   - CNT_RD: drive pred_re=1, pred_addr=cur.
//   - CNT_WAIT: if pred_data is FFFF or 0 -> FAIL.
//   - Else len+1 and cur=pred_data.
//   - If len > MAX_NODES -> FAIL.
//   - Else if cur==source -> WR_TERM, else -> CNT_RD.
//   - Each hop costs 2 cycles.
//  Pass 2, write (WR_TERM, WR_NODE, WR_RD, WR_WAIT)
//   - WR_TERM: write out[len] = 0000; set cur=destination, waddr=len-1.
//   - WR_NODE: write out[waddr] = cur. If cur==source -> DONE. Else issue pred read of cur -> WR_RD.
//   - WR_RD/WR_WAIT: cur=pred_data, waddr-1 -> WR_NODE.
//   - Pass 2 re-reads the same chain; the predecessor RAM must be static while busy.
//  FAIL
//   - Write out[0]=FFFF, then out[1]=0000 (two cycles); unreach=1; path_len=0 -> DONE.
//  DONE
//   - busy=0, done=1 -> IDLE.
//   - A start arriving while busy=1 is ignored.
//   - A start in the same cycle as the DONE transition is also ignored.
//  Width rules
//   - len and waddr are ADDR_W wide.
//   - MAX_NODES must be < 2**ADDR_W - 1 so that out[len] never wraps.
//   - The hop-limit compare happens before the increment can overflow.
//  Write order and latency
//   - Terminator is written first; nodes are then written at descending addresses.
//   - A reader polling done sees the complete image.
//   - Total latency = 4*(len-1) + 3 cycles from start to done.
// STRUCTURE
//  Shared package sp_pkg:
//   - ADDR_W, DATA_W
//   - NODE_NONE = 16'hFFFF
//   - PATH_TERM = 16'h0000
//   - FSM state encoding
//  No sub-modules: a single FSM plus counters. Memories stay outside this block.
// TESTING
//  (pred RAM model: 1-cycle read latency; result RAM model records every write.)
//  1 Chain: pred[4]=3, pred[3]=2, pred[2]=1; src=1, dst=4 -> out[0..4]=1,2,3,4,0000; path_len=4; unreach=0.
//  2 src=dst=5 -> out[0]=5, out[1]=0000; no pred_re pulses; path_len=1.
//  3 pred[4]=FFFF; src=1, dst=4 -> out[0]=FFFF, out[1]=0000; unreach=1; path_len=0.
//  4 Cycle: pred[2]=3, pred[3]=2; src=1, dst=2 -> FAIL after MAX_NODES hops;
//    out[0]=FFFF, out[1]=0000; unreach=1.
//  5 Start with n_exist_in=1 -> FFFF, 0000 within 3 cycles; no pred reads.
//  6 Reset asserted during pass 2 of test 1 -> out_we=0 from the next cycle; busy=0, done=0;
//    re-running test 1 produces the identical image.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared definitions for the shortest-path engine back end: memory widths,
// reserved predecessor/result words and the path-trace FSM encoding.
package sp_pkg;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 16;
  localparam int MAX_NODES = 256;

  localparam logic [DATA_W-1:0] NODE_NONE = 16'hFFFF;
  localparam logic [DATA_W-1:0] PATH_TERM = 16'h0000;

  typedef enum logic [3:0] {
    IDLE,
    CNT_RD,
    CNT_WAIT,
    WR_TERM,
    WR_NODE,
    WR_RD,
    WR_WAIT,
    FAIL,
    DONE
  } state_t;

  // Both reserved words mean "this node has no predecessor".
  function automatic logic no_pred(input logic [DATA_W-1:0] word);
    return (word == NODE_NONE) || (word == PATH_TERM);
  endfunction

endpackage

// File: rtl/path_trace_writer.sv
// Walks the predecessor RAM from destination back to source (pass 1 counts hops,
// pass 2 re-walks and writes) so the result RAM holds the path source-first, 0-terminated.
module path_trace_writer
  import sp_pkg::*;
#(
  parameter int ADDR_W    = sp_pkg::ADDR_W,
  parameter int DATA_W    = sp_pkg::DATA_W,
  parameter int MAX_NODES = sp_pkg::MAX_NODES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              n_exist_in,
  input  logic [DATA_W-1:0] source,
  input  logic [DATA_W-1:0] destination,
  output logic              pred_re,
  output logic [ADDR_W-1:0] pred_addr,
  input  logic [DATA_W-1:0] pred_data,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              unreach,
  output logic [ADDR_W-1:0] path_len
);

  localparam logic [ADDR_W-1:0] HOP_LIMIT = ADDR_W'(MAX_NODES);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] WORD_NONE = DATA_W'(NODE_NONE);
  localparam logic [DATA_W-1:0] WORD_TERM = DATA_W'(PATH_TERM);

  state_t            state_q;
  logic [DATA_W-1:0] src_q;
  logic [DATA_W-1:0] dst_q;
  logic [DATA_W-1:0] cur_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              fail_last_q;
  logic              failed_q;

  logic              pred_re_q;
  logic [ADDR_W-1:0] pred_addr_q;
  logic              out_we_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q;
  logic              done_q;
  logic              unreach_q;
  logic [ADDR_W-1:0] path_len_q;

  logic [ADDR_W-1:0] len_d;
  logic [DATA_W-1:0] node_d;
  logic [ADDR_W-1:0] waddr_d;
  logic              node_more_d;

  // The next node to write comes either from the destination (first node after
  // the terminator) or from the predecessor word returned for the previous node.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    len_d   = len_q + ADDR_ONE;
    node_d  = dst_q;
    waddr_d = len_q - ADDR_ONE;
    if (state_q == WR_RD) begin
      node_d  = pred_data;
      waddr_d = waddr_q - ADDR_ONE;
    end
    node_more_d = (node_d != src_q) && (waddr_d != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      cur_q       <= '0;
      len_q       <= '0;
      waddr_q     <= '0;
      fail_last_q <= 1'b0;
      failed_q    <= 1'b0;
      pred_re_q   <= 1'b0;
      pred_addr_q <= '0;
      out_we_q    <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      unreach_q   <= 1'b0;
      path_len_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; strobes default
      // low here so each state raises them for exactly the cycle it needs.
      pred_re_q <= 1'b0;
      out_we_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_q      <= source;
            dst_q      <= destination;
            cur_q      <= destination;
            len_q      <= ADDR_ONE;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            unreach_q  <= 1'b0;
            path_len_q <= '0;
            failed_q   <= 1'b0;
            if (n_exist_in) begin
              state_q     <= FAIL;
              failed_q    <= 1'b1;
              fail_last_q <= 1'b0;
              out_we_q    <= 1'b1;
              out_addr_q  <= '0;
              out_data_q  <= WORD_NONE;
            end else if (destination == source) begin
              state_q    <= WR_TERM;
              out_we_q   <= 1'b1;
              out_addr_q <= ADDR_ONE;
              out_data_q <= WORD_TERM;
            end else begin
              state_q     <= CNT_RD;
              pred_re_q   <= 1'b1;
              pred_addr_q <= destination[ADDR_W-1:0];
            end
          end
        end

        CNT_RD: state_q <= CNT_WAIT;

        CNT_WAIT: begin
          // Hop limit is tested on the pre-increment length so len never overflows.
          if (no_pred(pred_data) || (len_q >= HOP_LIMIT)) begin
            state_q     <= FAIL;
            failed_q    <= 1'b1;
            fail_last_q <= 1'b0;
            out_we_q    <= 1'b1;
            out_addr_q  <= '0;
            out_data_q  <= WORD_NONE;
          end else begin
            len_q <= len_d;
            cur_q <= pred_data;
            if (pred_data == src_q) begin
              state_q    <= WR_TERM;
              out_we_q   <= 1'b1;
              out_addr_q <= len_d;
              out_data_q <= WORD_TERM;
            end else begin
              state_q     <= CNT_RD;
              pred_re_q   <= 1'b1;
              pred_addr_q <= pred_data[ADDR_W-1:0];
            end
          end
        end

        // The pred read for the next node overlaps the write of the current one.
        WR_TERM, WR_RD: begin
          state_q     <= WR_NODE;
          cur_q       <= node_d;
          waddr_q     <= waddr_d;
          out_we_q    <= 1'b1;
          out_addr_q  <= waddr_d;
          out_data_q  <= node_d;
          pred_re_q   <= node_more_d;
          pred_addr_q <= node_d[ADDR_W-1:0];
        end

        WR_NODE: begin
          if ((cur_q == src_q) || (waddr_q == '0)) begin
            state_q <= DONE;
          end else begin
            state_q <= WR_RD;
          end
        end

        FAIL: begin
          if (!fail_last_q) begin
            fail_last_q <= 1'b1;
            out_we_q    <= 1'b1;
            out_addr_q  <= ADDR_ONE;
            out_data_q  <= WORD_TERM;
          end else begin
            state_q <= DONE;
          end
        end

        DONE: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          unreach_q  <= failed_q;
          path_len_q <= failed_q ? '0 : len_q;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign pred_re   = pred_re_q;
  assign pred_addr = pred_addr_q;
  assign out_we    = out_we_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign unreach   = unreach_q;
  assign path_len  = path_len_q;

endmodule

// File: tb/tb_path_trace_writer.sv
// Bench for path_trace_writer: directed chains plus randomized chains, breaks, cycles
// and negative-cycle starts, checked against a queue-based path walk.
module tb_path_trace_writer;

  localparam int AW   = 14;
  localparam int DW   = 16;
  localparam int MAXN = 256;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          n_exist_in;
  logic [DW-1:0] source;
  logic [DW-1:0] destination;
  logic          pred_re;
  logic [AW-1:0] pred_addr;
  logic [DW-1:0] pred_data;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          unreach;
  logic [AW-1:0] path_len;

  logic [DW-1:0] pred_mem [0:DEPTH-1];
  logic [DW-1:0] res_mem  [0:DEPTH-1];
  int            n_wr;
  int            n_rd;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_path [$];
  bit            exp_fail;
  int            exp_reads;

  path_trace_writer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .n_exist_in  (n_exist_in),
    .source      (source),
    .destination (destination),
    .pred_re     (pred_re),
    .pred_addr   (pred_addr),
    .pred_data   (pred_data),
    .out_we      (out_we),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .unreach     (unreach),
    .path_len    (path_len)
  );

  always #5 clock = ~clock;

  // Predecessor RAM with one-cycle read latency; result RAM logs every write.
  always @(posedge clock) begin
    if (pred_re) begin
      pred_data <= pred_mem[pred_addr];
      n_rd = n_rd + 1;
    end
    if (out_we) begin
      res_mem[out_addr] <= out_data;
      n_wr = n_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference walk: follow pred[] from destination until source, a missing
  // predecessor, or more than MAXN nodes on the path.
  function automatic void model(input logic [DW-1:0] s, input logic [DW-1:0] d, input bit nx);
    logic [DW-1:0] c;
    logic [DW-1:0] p;
    exp_path.delete();
    exp_fail  = 1'b0;
    exp_reads = 0;
    if (nx) begin
      exp_fail = 1'b1;
      return;
    end
    exp_path.push_front(d);
    c = d;
    while (c != s) begin
      p = pred_mem[c[AW-1:0]];
      exp_reads++;
      if (p == 16'hFFFF || p == 16'h0000) begin
        exp_fail = 1'b1;
        return;
      end
      exp_path.push_front(p);
      if (exp_path.size() > MAXN) begin
        exp_fail = 1'b1;
        return;
      end
      c = p;
    end
  endfunction

  task automatic clear_pred();
    for (int i = 0; i < DEPTH; i++) pred_mem[i] = 16'h0000;
  endtask

  task automatic run(input string tag, input logic [DW-1:0] s, input logic [DW-1:0] d,
                     input bit nx, input int abort_at, input bit glitch);
    int cnt;
    int exp_lat;
    int len;
    int wr0;
    bit got_done;
    model(s, d, nx);
    len = exp_path.size();
    if (exp_fail) exp_lat = 2 * exp_reads + 3;
    else          exp_lat = 4 * (len - 1) + 3;
    for (int i = 0; i < DEPTH; i++) res_mem[i] = 16'hAAAA;
    n_wr = 0;
    n_rd = 0;

    @(negedge clock);
    source      = s;
    destination = d;
    n_exist_in  = nx;
    start       = 1'b1;
    cnt      = 0;
    got_done = 1'b0;
    while (!got_done && cnt < 3000) begin
      @(posedge clock);
      #1;
      cnt++;
      start = 1'b0;
      // Scramble the sampled-with-start inputs once the walk is under way.
      source      = DW'($urandom);
      destination = DW'($urandom);
      n_exist_in  = 1'($urandom);
      if (cnt == 1) begin
        check({tag, "/busy_after_start"}, busy, 1);
        check({tag, "/done_cleared"}, done, 0);
      end
      if (abort_at != 0 && cnt == abort_at) begin
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check({tag, "/abort_out_we"}, out_we, 0);
        check({tag, "/abort_busy"}, busy, 0);
        check({tag, "/abort_done"}, done, 0);
        wr0 = n_wr;
        repeat (4) @(posedge clock);
        #1;
        check({tag, "/abort_no_more_writes"}, n_wr, wr0);
        return;
      end
      if (done) got_done = 1'b1;
      if (glitch && (cnt == 2 || cnt == exp_lat)) start = 1'b1;
    end
    start = 1'b0;
    check({tag, "/done_seen"}, got_done, 1);
    check({tag, "/latency"}, cnt - 1, exp_lat);
    check({tag, "/unreach"}, unreach, exp_fail);
    check({tag, "/path_len"}, path_len, exp_fail ? 0 : len);
    if (exp_fail) begin
      check({tag, "/out0_none"}, res_mem[0], 16'hFFFF);
      check({tag, "/out1_term"}, res_mem[1], 16'h0000);
      check({tag, "/write_count"}, n_wr, 2);
      check({tag, "/pred_reads"}, n_rd, exp_reads);
    end else begin
      for (int i = 0; i < len; i++)
        check($sformatf("%s/out%0d", tag, i), res_mem[i], exp_path[i]);
      check({tag, "/out_term"}, res_mem[len], 16'h0000);
      check({tag, "/write_count"}, n_wr, len + 1);
      check({tag, "/pred_reads"}, n_rd, 2 * (len - 1));
    end
    @(posedge clock);
    #1;
    check({tag, "/done_held"}, done, 1);
    check({tag, "/idle_after_done"}, busy, 0);
  endtask

  task automatic load_chain4();
    clear_pred();
    pred_mem[4] = 16'd3;
    pred_mem[3] = 16'd2;
    pred_mem[2] = 16'd1;
  endtask

  initial begin
    logic [DW-1:0] nodes [$];
    int            l;
    int            base;
    int            mode;
    int            k;
    logic [DW-1:0] s;
    logic [DW-1:0] d;

    reset       = 1'b1;
    start       = 1'b0;
    n_exist_in  = 1'b0;
    source      = '0;
    destination = '0;
    pred_data   = '0;
    n_wr        = 0;
    n_rd        = 0;
    clear_pred();
    repeat (3) @(posedge clock);
    #1;
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/out_we", out_we, 0);
    check("reset/pred_re", pred_re, 0);
    check("reset/unreach", unreach, 0);
    check("reset/path_len", path_len, 0);
    reset = 1'b0;

    load_chain4();
    run("chain4", 16'd1, 16'd4, 1'b0, 0, 1'b1);
    run("self", 16'd5, 16'd5, 1'b0, 0, 1'b1);
    clear_pred();
    pred_mem[4] = 16'hFFFF;
    run("no_pred", 16'd1, 16'd4, 1'b0, 0, 1'b0);
    clear_pred();
    pred_mem[2] = 16'd3;
    pred_mem[3] = 16'd2;
    run("cycle", 16'd1, 16'd2, 1'b0, 0, 1'b0);
    load_chain4();
    run("neg_cycle", 16'd1, 16'd4, 1'b1, 0, 1'b0);
    run("abort", 16'd1, 16'd4, 1'b0, 9, 1'b0);
    run("rerun", 16'd1, 16'd4, 1'b0, 0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      clear_pred();
      nodes.delete();
      l    = $urandom_range(1, 12);
      base = $urandom_range(1, 8000);
      mode = $urandom_range(0, 3);
      for (int i = 0; i < l; i++) nodes.push_back(DW'(base + 3 * i));
      for (int i = 1; i < l; i++) pred_mem[nodes[i]] = nodes[i-1];
      s = nodes[0];
      d = nodes[l-1];
      if (mode == 1 && l > 1) begin
        k = $urandom_range(1, l - 1);
        pred_mem[nodes[k]] = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
      end
      if (mode == 3) begin
        s = DW'(base + 3 * l + 5);
        pred_mem[nodes[0]] = nodes[l-1];
      end
      run($sformatf("rand%0d_m%0d", t, mode), s, d, mode == 2, 0, mode == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
